dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port synchronous data memory between the core load/store
//  path (requester C, single-word) and a loader/DMA engine (requester D,
//  bursts). Round-robin arbitration, one memory access per cycle.
//  Drives c_stall so the single-cycle core holds its PC while C is refused.
// PARAMETERS
//  ADDR_W     32  byte-address width on all address ports
//  DATA_W     32  data word width
//  LEN_W      4   burst-length field width; max burst = 2**LEN_W-1 beats
// PORTS
//  clock    in   1       rising-edge clock
//  reset    in   1       asynchronous, active-low; block in reset while 0
//  c_req    in   1       core access request (held until c_gnt)
//  c_we     in   1       1=store, 0=load
//  c_addr   in   ADDR_W  core byte address
//  c_wdata  in   DATA_W  store data
//  c_gnt    out  1       core access issued this cycle (comb.)
//  c_stall  out  1       c_req & ~c_gnt
//  c_rvalid out  1       load data valid (1 cycle after load grant)
//  c_rdata  out  DATA_W  load data
//  d_req    in   1       DMA burst request (held until first d_gnt)
//  d_we     in   1       burst direction, sampled at first beat
//  d_addr   in   ADDR_W  burst start byte address, sampled at first beat
//  d_len    in   LEN_W   beats in burst; 0 treated as 1
//  d_wdata  in   DATA_W  write data, sampled every cycle d_gnt=1
//  d_gnt    out  1       DMA beat issued this cycle (comb.)
//  d_rvalid out  1       read-beat data valid (1 cycle after beat)
//  d_rdata  out  DATA_W  read-beat data
//  d_done   out  1       1-cycle pulse in cycle of last beat
//  m_en     out  1       memory access strobe
//  m_we     out  1       memory write enable
//  m_addr   out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  m_wdata  out  DATA_W  memory write data
//  m_rdata  in   DATA_W  memory read data, valid cycle after m_en&~m_we
// BEHAVIOUR
//  Reset (reset=0): state IDLE, rr_ptr=C, beat counter 0, c_rvalid=d_rvalid=0,
//   d_done=0; comb. grants forced 0 so m_en=0. Reset mid-burst aborts burst;
//   remaining beats never issued, pending read data discarded.
//  FSM IDLE: winner = only requester, or on C&D both high the one rr_ptr
//   selects. C win: c_gnt=1, m_* from c_*, rr_ptr<=D, stay IDLE.
//   D win: d_gnt=1, m_addr=d_addr, latch d_we, addr+4, beats_left=len-1
//   (len 0/1 -> d_done=1, stay IDLE), else ->BURST; rr_ptr<=C.
//  FSM BURST: d_gnt=1 every cycle, m_addr=latched addr, addr+=4 (wraps mod
//   2**ADDR_W), beats_left-=1; last beat (beats_left==1) d_done=1, ->IDLE.
//   Burst is locked: c_req refused (c_stall=1) for whole burst; d_req ignored.
//   d_req dropping mid-burst does not abort.
//  Fairness: after a burst, pending C wins next IDLE cycle; after a C access,
//   pending D wins next. Max core wait = 2**LEN_W-1 cycles.
//  Read return: registered 1-cycle pipeline tags each read beat with owner;
//   c_rdata/d_rdata = m_rdata, rvalid asserted only for owner. Writes give no
//   rvalid. Read and write may be back-to-back with no bubble.
//  m_en = c_gnt|d_gnt; never both grants in one cycle. m_we = owner's we.
// TESTING
//  1 reset low mid-3rd beat of len-8 read burst -> all outputs 0 at once;
//    after release m_en=0 until new req; no stray d_rvalid.
//  2 C only: load 0x08 (mem=55) -> c_gnt cyc0, c_rvalid=1 c_rdata=55 cyc1.
//  3 C,D same cycle after reset -> C first; D then, rr alternates C,D,C.
//  4 D len=4 write @0x10 data 1..4 -> m_addr 0x10,14,18,1C 4 consecutive
//    cycles, d_done on 4th; C held c_stall=1 4 cycles, granted 5th.
//  5 D len=0 read @0x03 -> single beat m_addr=0x00, d_done same cycle.
//  6 D len=2 @0xFFFFFFFC -> m_addr 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory between
// the core load/store path (C, single word) and a loader/DMA engine (D, bursts).
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // core requester
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic              o_c_gnt,
  output logic              o_c_stall,
  output logic              o_c_rvalid,
  output logic [DATA_W-1:0] o_c_rdata,
  // DMA requester
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [LEN_W-1:0]  i_d_len,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_done,
  // memory
  output logic              o_m_en,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic [DATA_W-1:0] i_m_rdata
);

  typedef enum logic {S_IDLE, S_BURST} state_t;
  typedef enum logic {RR_C, RR_D}      rr_t;

  state_t             r_state;
  rr_t                r_rr_ptr;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_we;
  logic [LEN_W-1:0]   r_beats_left;
  logic               r_c_rvalid;
  logic               r_d_rvalid;

  logic               w_c_gnt;
  logic               w_d_gnt;
  logic               w_d_first;
  logic               w_d_done;
  logic               w_m_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_m_wdata;

  // Grant decode. Grants are gated by reset so the memory is never strobed
  // while the block is held in reset.
  // NOTE: every always_comb output gets a default first, otherwise a path
  // that skips an assignment infers a latch.
  always_comb begin
    w_c_gnt   = 1'b0;
    w_d_gnt   = 1'b0;
    w_d_first = 1'b0;
    w_d_done  = 1'b0;
    w_m_we    = 1'b0;
    w_addr    = '0;
    w_m_wdata = '0;
    if (i_rst_n) begin
      if (r_state == S_BURST) begin
        // locked burst: core and new DMA requests are both refused
        w_d_gnt  = 1'b1;
        w_d_done = (r_beats_left == LEN_W'(1));
      end else if (i_c_req && (!i_d_req || r_rr_ptr == RR_C)) begin
        w_c_gnt = 1'b1;
      end else if (i_d_req) begin
        w_d_gnt   = 1'b1;
        w_d_first = 1'b1;
        w_d_done  = (i_d_len <= LEN_W'(1));
      end

      if (w_c_gnt) begin
        w_addr    = i_c_addr;
        w_m_we    = i_c_we;
        w_m_wdata = i_c_wdata;
      end else if (w_d_gnt) begin
        w_addr    = (r_state == S_BURST) ? r_addr : i_d_addr;
        w_m_we    = (r_state == S_BURST) ? r_we   : i_d_we;
        w_m_wdata = i_d_wdata;
      end
    end
  end

  assign o_c_gnt   = w_c_gnt;
  assign o_d_gnt   = w_d_gnt;
  assign o_d_done  = w_d_done;
  assign o_c_stall = i_rst_n & i_c_req & ~w_c_gnt;
  assign o_m_en    = w_c_gnt | w_d_gnt;
  assign o_m_we    = w_m_we;
  assign o_m_addr  = w_addr & ~ADDR_W'(3);
  assign o_m_wdata = w_m_wdata;

  // Read data is shared; only the tagged owner sees it, zero otherwise.
  assign o_c_rvalid = r_c_rvalid;
  assign o_d_rvalid = r_d_rvalid;
  assign o_c_rdata  = r_c_rvalid ? i_m_rdata : '0;
  assign o_d_rdata  = r_d_rvalid ? i_m_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= RR_C;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_beats_left <= '0;
      r_c_rvalid   <= 1'b0;
      r_d_rvalid   <= 1'b0;
    end else begin
      r_c_rvalid <= w_c_gnt & ~w_m_we;
      r_d_rvalid <= w_d_gnt & ~w_m_we;

      if (w_c_gnt) begin
        r_rr_ptr <= RR_D;
      end

      if (w_d_first) begin
        r_rr_ptr     <= RR_C;
        r_we         <= i_d_we;
        r_addr       <= i_d_addr + ADDR_W'(4);
        r_beats_left <= (i_d_len == '0) ? '0 : i_d_len - LEN_W'(1);
        if (i_d_len > LEN_W'(1)) begin
          r_state <= S_BURST;
        end
      end

      if (r_state == S_BURST) begin
        r_addr       <= r_addr + ADDR_W'(4);
        r_beats_left <= r_beats_left - LEN_W'(1);
        if (r_beats_left == LEN_W'(1)) begin
          r_state <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a vector table for single-cycle
// arbitration plus hand-written sequences for bursts, wrap and reset abort.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  d_len;
  logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid, d_done;
  logic [31:0] c_rdata, d_rdata;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic [31:0] mem [0:63];
  int n_cmp = 0;
  int n_err = 0;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt), .o_c_stall(c_stall), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_len(d_len),
    .i_d_wdata(d_wdata), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid),
    .o_d_rdata(d_rdata), .o_d_done(d_done),
    .o_m_en(m_en), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
    .i_m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port synchronous memory, 64 words, indexed by address bits [7:2]
  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr[7:2]] <= m_wdata;
    if (m_en && !m_we) m_rdata <= mem[m_addr[7:2]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_len = 0; d_wdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr;
    logic        d_req, d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_len;
    logic [31:0] wdata;
    logic        e_cg, e_cs, e_dg, e_dd, e_men, e_mwe;
    logic [31:0] e_maddr;
    logic        e_crv, e_drv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt [10];

  initial begin
    // rr pointer starts at C; rvalid columns reflect the previous row's access
    //          creq cwe caddr     dreq dwe daddr     len  wdata      cg cs dg dd en we maddr      crv drv rdata
    vt[0] = '{0, 0, 32'h00, 0, 0, 32'h00, 4'd0, 32'h00,   0, 0, 0, 0, 0, 0, 32'h00,   0, 0, 32'h0};
    vt[1] = '{1, 0, 32'h08, 0, 0, 32'h00, 4'd0, 32'h00,   1, 0, 0, 0, 1, 0, 32'h08,   0, 0, 32'h0};
    vt[2] = '{1, 1, 32'h24, 1, 1, 32'h20, 4'd1, 32'hAA,   0, 1, 1, 1, 1, 1, 32'h20,   1, 0, 32'd55};
    vt[3] = '{1, 1, 32'h24, 1, 0, 32'h03, 4'd0, 32'hBB,   1, 0, 0, 0, 1, 1, 32'h24,   0, 0, 32'h0};
    vt[4] = '{0, 0, 32'h00, 1, 0, 32'h03, 4'd0, 32'h00,   0, 0, 1, 1, 1, 0, 32'h00,   0, 0, 32'h0};
    vt[5] = '{0, 0, 32'h00, 1, 0, 32'h0C, 4'd1, 32'h00,   0, 0, 1, 1, 1, 0, 32'h0C,   0, 1, 32'h100};
    vt[6] = '{1, 0, 32'h0D, 0, 0, 32'h00, 4'd0, 32'h00,   1, 0, 0, 0, 1, 0, 32'h0C,   0, 1, 32'h103};
    vt[7] = '{1, 0, 32'h14, 0, 0, 32'h00, 4'd0, 32'h00,   1, 0, 0, 0, 1, 0, 32'h14,   1, 0, 32'h103};
    vt[8] = '{0, 0, 32'h00, 1, 0, 32'h10, 4'd1, 32'h00,   0, 0, 1, 1, 1, 0, 32'h10,   1, 0, 32'h105};
    vt[9] = '{0, 0, 32'h00, 0, 0, 32'h00, 4'd0, 32'h00,   0, 0, 0, 0, 0, 0, 32'h00,   0, 1, 32'h104};

    for (int i = 0; i < 64; i++) mem[i] = 32'h100 + i;
    mem[2] = 32'd55;
    m_rdata = 0;

    // reset state: grants forced low even with both requests asserted
    rst_n = 0;
    idle_inputs();
    c_req = 1; d_req = 1; d_len = 4'd3;
    #12;
    check("rst m_en", m_en, 0);
    check("rst c_gnt", c_gnt, 0);
    check("rst d_gnt", d_gnt, 0);
    check("rst d_done", d_done, 0);
    check("rst rvalid", {c_rvalid, d_rvalid}, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    tick();

    // table: single-cycle arbitration, alignment, len 0/1, read return
    for (int i = 0; i < 10; i++) begin
      c_req = vt[i].c_req; c_we = vt[i].c_we; c_addr = vt[i].c_addr;
      d_req = vt[i].d_req; d_we = vt[i].d_we; d_addr = vt[i].d_addr;
      d_len = vt[i].d_len; c_wdata = vt[i].wdata; d_wdata = vt[i].wdata;
      @(negedge clk);
      check($sformatf("v%0d c_gnt", i), c_gnt, vt[i].e_cg);
      check($sformatf("v%0d c_stall", i), c_stall, vt[i].e_cs);
      check($sformatf("v%0d d_gnt", i), d_gnt, vt[i].e_dg);
      check($sformatf("v%0d d_done", i), d_done, vt[i].e_dd);
      check($sformatf("v%0d m_en", i), m_en, vt[i].e_men);
      check($sformatf("v%0d m_we", i), m_we, vt[i].e_mwe);
      check($sformatf("v%0d m_addr", i), m_addr, vt[i].e_maddr);
      check($sformatf("v%0d c_rvalid", i), c_rvalid, vt[i].e_crv);
      check($sformatf("v%0d d_rvalid", i), d_rvalid, vt[i].e_drv);
      if (vt[i].e_mwe) check($sformatf("v%0d m_wdata", i), m_wdata, vt[i].wdata);
      if (vt[i].e_crv) check($sformatf("v%0d c_rdata", i), c_rdata, vt[i].e_rdata);
      if (vt[i].e_drv) check($sformatf("v%0d d_rdata", i), d_rdata, vt[i].e_rdata);
      tick();
    end

    // len-4 write burst locks out the core, which is granted on cycle 5
    idle_inputs();
    c_req = 1; c_addr = 32'h00;
    @(negedge clk);
    check("b4 pre c_gnt", c_gnt, 1);
    tick();
    c_addr = 32'h04;
    d_req = 1; d_we = 1; d_addr = 32'h10; d_len = 4'd4;
    for (int i = 0; i < 4; i++) begin
      d_wdata = i + 1;
      @(negedge clk);
      check($sformatf("b4 beat%0d d_gnt", i), d_gnt, 1);
      check($sformatf("b4 beat%0d m_addr", i), m_addr, 32'h10 + 4 * i);
      check($sformatf("b4 beat%0d m_we", i), m_we, 1);
      check($sformatf("b4 beat%0d m_wdata", i), m_wdata, i + 1);
      check($sformatf("b4 beat%0d c_stall", i), c_stall, 1);
      check($sformatf("b4 beat%0d d_done", i), d_done, (i == 3) ? 1 : 0);
      tick();
      d_req = 0;
    end
    @(negedge clk);
    check("b4 post c_gnt", c_gnt, 1);
    check("b4 post c_stall", c_stall, 0);
    check("b4 post d_gnt", d_gnt, 0);
    tick();
    idle_inputs();
    check("b4 mem[5]", mem[5], 2);
    check("b4 mem[7]", mem[7], 4);

    // len-2 read burst wraps the address space
    d_req = 1; d_we = 0; d_addr = 32'hFFFF_FFFC; d_len = 4'd2;
    @(negedge clk);
    check("wrap beat0 m_addr", m_addr, 32'hFFFF_FFFC);
    check("wrap beat0 d_done", d_done, 0);
    tick();
    d_req = 0;
    @(negedge clk);
    check("wrap beat1 d_gnt", d_gnt, 1);
    check("wrap beat1 m_addr", m_addr, 32'h0000_0000);
    check("wrap beat1 d_done", d_done, 1);
    check("wrap beat1 d_rdata", {d_rvalid, d_rdata}, {1'b1, 32'h13F});
    tick();
    @(negedge clk);
    check("wrap tail d_rdata", {d_rvalid, d_rdata}, {1'b1, 32'h100});
    check("wrap tail m_en", m_en, 0);
    tick();

    // after reset both request together: C, D, C, D
    do_reset();
    c_req = 1; c_addr = 32'h04; d_req = 1; d_addr = 32'h0C; d_len = 4'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rr%0d c_gnt", i), c_gnt, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d d_gnt", i), d_gnt, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    idle_inputs();
    tick();

    // reset asserted mid 3rd beat of a len-8 read burst
    d_req = 1; d_addr = 32'h00; d_len = 4'd8;
    tick();
    d_req = 0;
    tick();
    check("abort beat3 d_gnt", d_gnt, 1);
    check("abort beat3 m_addr", m_addr, 32'h08);
    #2 rst_n = 0;
    #1;
    check("abort m_en", m_en, 0);
    check("abort d_gnt", d_gnt, 0);
    check("abort d_rvalid", d_rvalid, 0);
    check("abort outs", {c_gnt, c_stall, c_rvalid, d_done, m_we, m_addr}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("post%0d m_en", i), m_en, 0);
      check($sformatf("post%0d d_rvalid", i), d_rvalid, 0);
    end
    tick();
    c_req = 1; c_addr = 32'h08;
    @(negedge clk);
    check("post new c_gnt", c_gnt, 1);
    tick();
    idle_inputs();
    @(negedge clk);
    check("post c_rdata", {c_rvalid, c_rdata}, {1'b1, 32'd55});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
